// File: rtl/scan_sequencer_4bit.sv
// 4-bit select-code sequencer for the 4x16 line decoder: prescaled up/down scan, single sweep or hold.
// Optional SCAN_SKIP_MASK_EN adds i_skip_mask to exclude positions from the scan.
module scan_sequencer_4bit #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_single,
   input  logic        i_stop,
   input  logic        i_dir,
   input  logic        i_load,
   input  logic [3:0]  i_load_val,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [15:0] i_skip_mask,
`endif
   output logic [3:0]  o_sel,
   output logic        o_busy,
   output logic        o_wrap,
   output logic        o_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      SWEEP = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(PRESCALE - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [3:0] r_sel;
   logic       r_busy;
   logic       r_wrap;
   logic       r_done;

   logic [3:0] w_next;
   logic       w_cross;
   logic       w_valid;
   logic       w_step_due;

   assign w_step_due = (r_cnt == CNT_LAST);

`ifdef SCAN_SKIP_MASK_EN
   logic [5:0] w_sum;

   // Search up to a full lap for the next unmasked position; landing back on
   // the current position after a lap still counts as crossing the boundary.
   always_comb begin
      w_next  = r_sel;
      w_cross = 1'b0;
      w_valid = 1'b0;
      w_sum   = '0;
      for (int unsigned k = 1; k <= 16; k++) begin
         if (!w_valid) begin
            if (!i_dir)
               w_sum = 6'(r_sel) + 6'(k);
            else
               w_sum = 6'(r_sel) + 6'd16 - 6'(k);
            if (!i_skip_mask[w_sum[3:0]]) begin
               w_valid = 1'b1;
               w_next  = w_sum[3:0];
               w_cross = i_dir ? (6'(k) > 6'(r_sel)) : (w_sum > 6'd15);
            end
         end
      end
   end
`else
   always_comb begin
      w_valid = 1'b1;
      w_next  = i_dir ? (r_sel - 4'd1) : (r_sel + 4'd1);
      w_cross = i_dir ? (r_sel == 4'd0) : (r_sel == 4'd15);
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_busy  <= 1'b0;
         r_wrap  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         r_done <= 1'b0;
         if (i_load) begin
            r_sel <= i_load_val;
            r_cnt <= '0;
            if (i_stop) begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         end else if (i_stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt <= '0;
                  if (i_start) begin
                     r_state <= RUN;
                     r_busy  <= 1'b1;
                  end else if (i_single) begin
                     r_state <= SWEEP;
                     r_busy  <= 1'b1;
                  end
               end
               RUN, SWEEP: begin
                  if (w_step_due) begin
                     r_cnt <= '0;
                     if (w_valid) begin
                        r_sel  <= w_next;
                        r_wrap <= w_cross;
                        if (r_state == SWEEP && w_cross) begin
                           r_state <= IDLE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end
                     end
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign o_sel  = r_sel;
   assign o_busy = r_busy;
   assign o_wrap = r_wrap;
   assign o_done = r_done;

endmodule
